duck_round_controller: RTL and testbench
========================================

# duck_round_controller

Sequences one round of duck hunting for the video datapath, on the pixel clock alongside `color_mapper`. It detects trigger presses and runs the shot-flash frame. It performs the cursor-vs-duck hit test and counts remaining shots, hits and ducks. It drives the `shot_on`, shot-count, `duckresetSignal` and `Duck_color` controls that the color mapper consumes.

## Interface
Parameters:
- SHOTS, 3: shots allowed per duck; max 3 (`shot_count` is 2 bits).
- DUCK_SIZE, 64: duck sprite bounding-box edge, in pixels.
- FALL_FRAMES, 60: frames spent in FALL or ESCAPE before the next duck.
- ESCAPE_FRAMES, 600: frames a duck flies unshot before it escapes.
- DUCKS_PER_ROUND, 10: ducks per round.

Ports:
- vga_clk  in  1  pixel clock; the only clock.
- Reset  in  1  synchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at the first pixel of each frame.
- start  in  1  one-cycle pulse that begins a round.
- MouseButtons  in  8  mouse button byte; value 8'd2 means the left button is held.
- BallX, BallY  in  10 each  cursor centre position.
- Duck_X, Duck_Y  in  10 each  duck sprite top-left position.
- shot_on  out  1  high for the whole flash frame.
- shot_count  out  2  shots used on the current duck; drives the ammo squares.
- duck_hit  out  1  high while the duck falls.
- duckresetSignal  out  1  high hides the duck.
- Duck_color  out  2  duck color: 0 black, 1 red, 2 pink.
- hits  out  4  ducks hit this round.
- ducks_done  out  4  ducks finished this round.
- game_over  out  1  high when the round is complete.

## Operation
- Trigger detect:
  - `btn` is a register of (MouseButtons == 8'd2).
  - `btn_d` is `btn` delayed one cycle.
  - `press = btn & ~btn_d`.
- LFSR:
  - 8 bits, seed 8'hA5 on reset, taps x^8+x^6+x^5+x^4+1.
  - Advances every cycle.
  - Supplies the duck color from its bits [1:0]; value 3 maps to 0.
- IDLE: duckresetSignal=1. On `start`: clear hits, ducks_done and shot_count; load Duck_color from the LFSR; go to FLY.
- FLY: duckresetSignal=0. The frame counter `esc_cnt` counts frame_start pulses.
  - On `press` with shot_count < SHOTS: increment shot_count. Latch `hit_l`, which is 1 iff both 10-bit differences (BallX−Duck_X) and (BallY−Duck_Y) are < DUCK_SIZE (unsigned; negative differences wrap large, so they count as misses). Go to ARMED.
  - Else, on esc_cnt reaching ESCAPE_FRAMES: go to ESCAPE.
- ARMED: wait for the next frame_start, then go to FLASH. Ignore presses.
- FLASH: shot_on=1. Ignore presses. On the next frame_start:
  - hit_l=1 → FALL, and increment hits.
  - Otherwise, shot_count == SHOTS → ESCAPE.
  - Otherwise → FLY; esc_cnt is not cleared.
- FALL: duck_hit=1. ESCAPE: duck flies off, duck_hit=0. Both last FALL_FRAMES frame_start pulses, then go to NEXT.
- NEXT: lasts one cycle with duckresetSignal=1.
  - Increment ducks_done; clear shot_count, esc_cnt and hit_l; load Duck_color from the LFSR.
  - If the new ducks_done == DUCKS_PER_ROUND → OVER, else → FLY.
- OVER: game_over=1, duckresetSignal=1. On `start`: behave as in IDLE.
- `start` in any other state is ignored.
- Counters saturate: hits and ducks_done at 15, shot_count at SHOTS.

## Timing
- Reset (Reset=0 at a vga_clk edge, in any state) forces, on that edge:
  - state=IDLE
  - shot_on=0, shot_count=0, duck_hit=0, duckresetSignal=1
  - Duck_color=0, hits=0, ducks_done=0, game_over=0
  - btn=btn_d=0, LFSR=8'hA5
- All outputs are registered and change only on vga_clk edges.
- Press latency: the button is sampled into `btn` at edge N. `press` is high during the cycle after edge N, so it is acted on at edge N+1. At edge N+1 shot_count updates and the state becomes ARMED.
- Flash: shot_on rises on the edge of the first frame_start after ARMED is entered, and falls exactly one frame later. If a press is accepted on the same edge as a frame_start, that frame_start does not arm the flash; the following one does.
- A press and esc_cnt reaching ESCAPE_FRAMES on the same edge: the press wins.
- Hit test uses only the positions latched at press time; later duck motion does not change the result.
- A held button produces exactly one press; re-arming needs a release.

## Test plan
- Reset: hold Reset=0 for 2 cycles in FLY → all outputs at their reset values, state IDLE, duckresetSignal=1.
- Hit: after start, Duck_X=Duck_Y=100, BallX=BallY=130, one press → after edge N+1 shot_count=1; shot_on high for exactly one frame; then duck_hit=1 for 60 frames and hits=1; then a 1-cycle NEXT and ducks_done=1.
- Three misses: BallX=10, Duck_X=100, three separated presses → shot_count 1, 2, 3; three flash frames; ESCAPE after the third; ducks_done=1, hits=0.
- Boundary: BallX=Duck_X+63 is a hit, BallX=Duck_X+64 is a miss, BallX=Duck_X−1 is a miss (wrap).
- Held button for 1000 cycles → exactly one shot; press during ARMED or FLASH → shot_count unchanged.
- Escape and round end: no presses → ESCAPE entered at frame 600, NEXT after 60 more frames; after 10 ducks game_over=1; start → hits=0, ducks_done=0, state FLY.

Source files
------------

// File: rtl/duck_round_controller.sv
// duck_round_controller: trigger detect, shot flash, hit test and per-round duck/shot scoring
module duck_round_controller #(
  parameter int SHOTS = 3,
  parameter int DUCK_SIZE = 64,
  parameter int FALL_FRAMES = 60,
  parameter int ESCAPE_FRAMES = 600,
  parameter int DUCKS_PER_ROUND = 10
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic       frame_start,
  input  logic       start,
  input  logic [7:0] MouseButtons,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic [9:0] Duck_X,
  input  logic [9:0] Duck_Y,
  output logic       shot_on,
  output logic [1:0] shot_count,
  output logic       duck_hit,
  output logic       duckresetSignal,
  output logic [1:0] Duck_color,
  output logic [3:0] hits,
  output logic [3:0] ducks_done,
  output logic       game_over
);
  localparam int EW = $clog2(ESCAPE_FRAMES + 2);
  localparam int FW = $clog2(FALL_FRAMES + 1);
  typedef enum logic [2:0] {IDLE, FLY, ARMED, FLASH, FALL, ESCAPE, NEXT, OVER} state_t;
  state_t state;
  logic btn, btn_d, hit_l, press, hit_now, shot_ok, fall_end;
  logic [7:0] lfsr;
  logic [EW-1:0] esc_cnt, esc_n;
  logic [FW-1:0] fcnt;
  logic [9:0] dx, dy;
  logic [1:0] color;
  logic [3:0] done_n;
  always_comb begin
    press = btn & ~btn_d;
    dx = BallX - Duck_X;
    dy = BallY - Duck_Y;
    hit_now = dx < 10'(DUCK_SIZE) && dy < 10'(DUCK_SIZE);
    shot_ok = press && shot_count < 2'(SHOTS);
    color = lfsr[1:0] == 2'd3 ? 2'd0 : lfsr[1:0];
    done_n = ducks_done == 4'd15 ? ducks_done : ducks_done + 4'd1;
    esc_n = esc_cnt + EW'(frame_start);
    fall_end = fcnt == FW'(FALL_FRAMES - 1);
  end
  always_ff @(posedge vga_clk) begin
    if (!Reset) begin
      state <= IDLE;
      shot_on <= 1'b0;
      shot_count <= '0;
      duck_hit <= 1'b0;
      duckresetSignal <= 1'b1;
      Duck_color <= '0;
      hits <= '0;
      ducks_done <= '0;
      game_over <= 1'b0;
      btn <= 1'b0;
      btn_d <= 1'b0;
      lfsr <= 8'hA5;
      hit_l <= 1'b0;
      esc_cnt <= '0;
      fcnt <= '0;
    end else begin
      btn <= MouseButtons == 8'd2;
      btn_d <= btn;
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      case (state)
        IDLE, OVER: if (start) begin
          hits <= '0;
          ducks_done <= '0;
          shot_count <= '0;
          esc_cnt <= '0;
          hit_l <= 1'b0;
          Duck_color <= color;
          game_over <= 1'b0;
          duckresetSignal <= 1'b0;
          state <= FLY;
        end
        FLY: begin
          esc_cnt <= esc_n;
          if (shot_ok) begin
            shot_count <= shot_count + 2'd1;
            hit_l <= hit_now;
            state <= ARMED;
          end else if (esc_n >= EW'(ESCAPE_FRAMES)) state <= ESCAPE;
        end
        ARMED: if (frame_start) begin
          shot_on <= 1'b1;
          state <= FLASH;
        end
        FLASH: if (frame_start) begin
          shot_on <= 1'b0;
          if (hit_l) begin
            duck_hit <= 1'b1;
            hits <= hits == 4'd15 ? hits : hits + 4'd1;
            state <= FALL;
          end else state <= shot_count == 2'(SHOTS) ? ESCAPE : FLY;
        end
        FALL, ESCAPE: if (frame_start) begin
          fcnt <= fall_end ? '0 : fcnt + FW'(1);
          if (fall_end) begin
            duck_hit <= 1'b0;
            duckresetSignal <= 1'b1;
            state <= NEXT;
          end
        end
        NEXT: begin
          ducks_done <= done_n;
          shot_count <= '0;
          esc_cnt <= '0;
          hit_l <= 1'b0;
          Duck_color <= color;
          game_over <= done_n == 4'(DUCKS_PER_ROUND);
          duckresetSignal <= done_n == 4'(DUCKS_PER_ROUND);
          state <= done_n == 4'(DUCKS_PER_ROUND) ? OVER : FLY;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_duck_round_controller.sv
// tb_duck_round_controller: scoreboard bench comparing duck_round_controller against a phase-level reference model
module tb_duck_round_controller;
  logic vga_clk = 1'b0, Reset = 1'b0, frame_start = 1'b0, start = 1'b0;
  logic [7:0] MouseButtons = '0;
  logic [9:0] BallX = '0, BallY = '0, Duck_X = '0, Duck_Y = '0;
  logic shot_on, duck_hit, duckresetSignal, game_over;
  logic [1:0] shot_count, Duck_color;
  logic [3:0] hits, ducks_done;
  int errors = 0, checks = 0, cyc = 0, fcd = 2;
  string tag = "reset";
  typedef struct packed {
    logic so;
    logic [1:0] sc;
    logic dh;
    logic dr;
    logic [1:0] col;
    logic [3:0] hits;
    logic [3:0] done;
    logic go;
  } obs_t;
  obs_t exp_q[$];
  typedef enum {M_IDLE, M_FLY, M_ARMED, M_FLASH, M_FALL, M_ESC, M_NEXT, M_OVER} phase_t;
  phase_t ph = M_IDLE;
  int shots = 0, hits_m = 0, done_m = 0, flown = 0, left = 0;
  logic [1:0] color_m = '0;
  logic [7:0] lf = 8'hA5;
  bit hit_m = 0, b = 0, b_d = 0;

  duck_round_controller dut (
    .vga_clk(vga_clk), .Reset(Reset), .frame_start(frame_start), .start(start),
    .MouseButtons(MouseButtons), .BallX(BallX), .BallY(BallY), .Duck_X(Duck_X), .Duck_Y(Duck_Y),
    .shot_on(shot_on), .shot_count(shot_count), .duck_hit(duck_hit), .duckresetSignal(duckresetSignal),
    .Duck_color(Duck_color), .hits(hits), .ducks_done(ducks_done), .game_over(game_over)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic bit inside_box(logic [9:0] p, logic [9:0] q);
    return ((int'(p) - int'(q) + 1024) % 1024) < 64;
  endfunction

  task automatic model();
    bit press;
    logic [1:0] c;
    if (!Reset) begin
      ph = M_IDLE; shots = 0; hits_m = 0; done_m = 0; flown = 0; left = 0;
      color_m = '0; hit_m = 0; b = 0; b_d = 0; lf = 8'hA5;
      return;
    end
    press = b && !b_d;
    c = (lf[1:0] == 2'd3) ? 2'd0 : lf[1:0];
    case (ph)
      M_IDLE, M_OVER: if (start) begin
        hits_m = 0; done_m = 0; shots = 0; flown = 0; hit_m = 0; color_m = c; ph = M_FLY;
      end
      M_FLY: begin
        if (frame_start) flown++;
        if (press && shots < 3) begin
          shots++;
          hit_m = inside_box(BallX, Duck_X) && inside_box(BallY, Duck_Y);
          ph = M_ARMED;
        end else if (flown >= 600) begin
          ph = M_ESC; left = 60;
        end
      end
      M_ARMED: if (frame_start) ph = M_FLASH;
      M_FLASH: if (frame_start) begin
        if (hit_m) begin
          ph = M_FALL; left = 60; if (hits_m < 15) hits_m++;
        end else if (shots == 3) begin
          ph = M_ESC; left = 60;
        end else ph = M_FLY;
      end
      M_FALL, M_ESC: if (frame_start) begin
        left--; if (left == 0) ph = M_NEXT;
      end
      M_NEXT: begin
        if (done_m < 15) done_m++;
        shots = 0; flown = 0; hit_m = 0; color_m = c;
        ph = (done_m == 10) ? M_OVER : M_FLY;
      end
    endcase
    b_d = b;
    b = (MouseButtons == 8'd2);
    lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
  endtask

  task automatic step();
    obs_t e;
    frame_start = (fcd == 0);
    fcd = (fcd == 0) ? int'($urandom_range(6, 3)) : fcd - 1;
    model();
    e.so = ph == M_FLASH;
    e.sc = 2'(shots);
    e.dh = ph == M_FALL;
    e.dr = ph == M_IDLE || ph == M_NEXT || ph == M_OVER;
    e.col = color_m;
    e.hits = 4'(hits_m);
    e.done = 4'(done_m);
    e.go = ph == M_OVER;
    exp_q.push_back(e);
    @(negedge vga_clk);
  endtask

  initial forever begin
    obs_t g, e;
    @(posedge vga_clk);
    #1;
    cyc++;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = {shot_on, shot_count, duck_hit, duckresetSignal, Duck_color, hits, ducks_done, game_over};
      checks++;
      if (g != e) begin
        errors++;
        $display("FAIL %s cycle %0d: got so=%0d sc=%0d dh=%0d drst=%0d col=%0d hits=%0d done=%0d go=%0d, want so=%0d sc=%0d dh=%0d drst=%0d col=%0d hits=%0d done=%0d go=%0d",
          tag, cyc, g.so, g.sc, g.dh, g.dr, g.col, g.hits, g.done, g.go, e.so, e.sc, e.dh, e.dr, e.col, e.hits, e.done, e.go);
      end
    end
  end

  task automatic check(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s/%s: got %0d want %0d", tag, name, got, want);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic shoot(logic [9:0] bx, logic [9:0] by);
    BallX = bx; BallY = by;
    MouseButtons = 8'd2; step(); step();
    MouseButtons = 8'd0;
    repeat (30) step();
  endtask

  task automatic finish_duck();
    int d0 = done_m;
    int n = 0;
    MouseButtons = 8'd0;
    while (done_m == d0 && ph != M_OVER && n < 20000) begin step(); n++; end
    if (n >= 20000) begin
      checks++; errors++;
      $display("FAIL %s/duck_end: got no duck end within 20000 cycles want duck end", tag);
    end
  endtask

  initial begin
    int n;
    bit hold;
    @(negedge vga_clk);
    repeat (3) step();
    Reset = 1'b1;
    step();
    check("reset_drst", duckresetSignal, 1);
    check("reset_sc", shot_count, 0);
    check("reset_hits", hits, 0);
    check("reset_go", game_over, 0);
    check("reset_col", Duck_color, 0);

    tag = "reset_in_fly";
    pulse_start();
    repeat (5) step();
    Reset = 1'b0; step(); step(); Reset = 1'b1;
    check("drst_after_reset", duckresetSignal, 1);
    check("sc_after_reset", shot_count, 0);
    step();

    tag = "hit";
    Duck_X = 10'd100; Duck_Y = 10'd100;
    pulse_start();
    shoot(10'd130, 10'd130);
    finish_duck();
    check("hits", hits, 1);
    check("done", ducks_done, 1);

    tag = "three_misses";
    repeat (3) shoot(10'd10, 10'd100);
    finish_duck();
    check("hits", hits, 1);
    check("done", ducks_done, 2);

    tag = "edge_63";
    shoot(10'd163, 10'd163);
    finish_duck();
    check("hits", hits, 2);
    tag = "edge_64";
    repeat (3) shoot(10'd164, 10'd100);
    finish_duck();
    check("hits", hits, 2);
    tag = "edge_minus1";
    repeat (3) shoot(10'd99, 10'd100);
    finish_duck();
    check("hits", hits, 2);
    check("done", ducks_done, 5);

    tag = "held";
    BallX = 10'd300; BallY = 10'd300;
    MouseButtons = 8'd2;
    repeat (1000) step();
    check("held_shots", shot_count, 1);
    finish_duck();

    tag = "escape";
    finish_duck();
    check("done", ducks_done, 7);

    tag = "random_round";
    hold = 0; n = 0;
    while (ph != M_OVER && n < 40000) begin
      if ($urandom_range(0, 7) == 0) hold = ~hold;
      MouseButtons = hold ? 8'd2 : ($urandom_range(0, 9) == 0 ? 8'($urandom) : 8'd0);
      Duck_X = 10'($urandom_range(0, 900));
      Duck_Y = 10'($urandom_range(0, 700));
      BallX = Duck_X + 10'($urandom_range(0, 80)) - 10'd8;
      BallY = Duck_Y + 10'($urandom_range(0, 80)) - 10'd8;
      step();
      n++;
    end
    if (n >= 40000) begin
      checks++; errors++;
      $display("FAIL %s/round_end: got no game over within 40000 cycles want game over", tag);
    end
    MouseButtons = 8'd0;
    step();
    check("go", game_over, 1);
    check("done", ducks_done, 10);

    tag = "restart";
    pulse_start();
    check("done", ducks_done, 0);
    check("hits", hits, 0);
    check("go", game_over, 0);
    check("drst", duckresetSignal, 0);

    tag = "random_reset";
    hold = 0;
    repeat (4000) begin
      if ($urandom_range(0, 5) == 0) hold = ~hold;
      MouseButtons = hold ? 8'd2 : 8'd0;
      start = $urandom_range(0, 40) == 0;
      Reset = $urandom_range(0, 600) != 0;
      Duck_X = 10'($urandom);
      Duck_Y = 10'($urandom);
      BallX = Duck_X + 10'($urandom_range(0, 70)) - 10'd4;
      BallY = Duck_Y + 10'($urandom_range(0, 70)) - 10'd4;
      step();
    end
    Reset = 1'b1; start = 1'b0;
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
